// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with a single-entry command holding register,
// ack handshake, frame-error pulse and sticky overrun flag.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] command,
  output logic       ready_command,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
  state_e          state_q, state_d;
  logic            rx_m_q, rx_s_q, armed_q;
  logic [1:0]      prime_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d, cmd_q;
  logic            rdy_q, fe_q, ov_q;
  logic            full, half, done, bad, take;
  assign full = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign half = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  assign command       = cmd_q;
  assign ready_command = rdy_q;
  assign frame_err     = fe_q;
  assign overrun       = ov_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      prime_q <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      cmd_q   <= '0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      prime_q <= {prime_q[0], 1'b1};
      // only arm once the real line has been seen high after reset
      armed_q <= armed_q | (prime_q[1] & rx_s_q);
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      fe_q    <= bad;
      if (done && (!rdy_q || take)) begin
        cmd_q <= sh_q;
        rdy_q <= 1'b1;
      end else if (done) begin
        ov_q <= 1'b1;
      end else if (take) begin
        rdy_q <= 1'b0;
        ov_q  <= 1'b0;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = (!rx_s_q && armed_q) ? START : IDLE;
      START:     state_d = half ? (rx_s_q ? IDLE : DATA) : START;
      DATA:      state_d = (full && idx_q == 3'd7) ? STOP : DATA;
      STOP:      state_d = full ? (rx_s_q ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: state_d = rx_s_q ? IDLE : WAIT_IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    done  = state_q == STOP && full && rx_s_q;
    bad   = state_q == STOP && full && !rx_s_q;
    take  = ack && rdy_q;
    cnt_d = (state_q inside {START, DATA, STOP} && state_d == state_q && !full) ? cnt_q + 1'b1 : '0;
    idx_d = state_q == DATA ? (full ? idx_q + 3'd1 : idx_q) : 3'd0;
    sh_d  = sh_q;
    if (state_q == DATA && full) sh_d[idx_q] = rx_s_q;
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed checks of uart_cmd_rx at 16 clocks per bit.
module tb_uart_cmd_rx;
  logic       clk = 1'b0;
  logic       rst, rx, ack;
  logic [7:0] command;
  logic       ready_command, frame_err, overrun;
  int         checks = 0, errors = 0, fe_cnt = 0, fe_base, bad_hold;
  logic       rdy154, rdy155, fe155;

  uart_cmd_rx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .command(command), .ready_command(ready_command),
    .ack(ack), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive the first n of the 160 cycles of a frame; the stop sample lands on edge 155.
  task automatic send(input logic [7:0] d, input logic stp, input bit ack_done, input int n);
    logic [9:0] fr;
    fr = {stp, d, 1'b0};
    for (int c = 0; c < n; c++) begin
      rx = fr[c / 16];
      @(posedge clk); #1;
      if (c + 1 == 154) begin
        rdy154 = ready_command;
        if (ack_done) ack = 1'b1;
      end
      if (c + 1 == 155) begin
        ack = 1'b0;
        rdy155 = ready_command;
        fe155 = frame_err;
      end
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; ack = 1'b0;
    cycles(3);
    chk("rst_cmd", command, 8'h00);
    chk("rst_rdy", 8'(ready_command), 8'h00);
    chk("rst_fe", 8'(frame_err), 8'h00);
    chk("rst_ov", 8'(overrun), 8'h00);
    rst = 1'b1;
    cycles(5);
    send(8'h05, 1'b1, 1'b0, 160);
    chk("f05_rdy_before", 8'(rdy154), 8'h00);
    chk("f05_rdy_after", 8'(rdy155), 8'h01);
    chk("f05_cmd", command, 8'h05);
    chk("f05_ov", 8'(overrun), 8'h00);
    bad_hold = 0;
    repeat (100) begin
      cycles(1);
      if (command !== 8'h05 || ready_command !== 1'b1) bad_hold++;
    end
    chk("f05_hold", 8'(bad_hold), 8'h00);
    ack_pulse();
    chk("f05_ack_clear", 8'(ready_command), 8'h00);
    cycles(20);
    fe_base = fe_cnt;
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(30);
    chk("glitch_rdy", 8'(ready_command), 8'h00);
    chk("glitch_fe", 8'(fe_cnt - fe_base), 8'h00);
    fe_base = fe_cnt;
    send(8'hA3, 1'b0, 1'b0, 160);
    chk("fA3_fe_pulse", 8'(fe155), 8'h01);
    cycles(40);
    rx = 1'b1;
    cycles(20);
    chk("fA3_fe_count", 8'(fe_cnt - fe_base), 8'h01);
    chk("fA3_rdy", 8'(ready_command), 8'h00);
    send(8'h3C, 1'b1, 1'b0, 160);
    cycles(5);
    chk("f3C_cmd", command, 8'h3C);
    chk("f3C_rdy", 8'(ready_command), 8'h01);
    ack_pulse();
    chk("f3C_ack_clear", 8'(ready_command), 8'h00);
    cycles(10);
    send(8'h01, 1'b1, 1'b0, 160);
    send(8'h02, 1'b1, 1'b0, 160);
    cycles(2);
    chk("ovr_cmd", command, 8'h01);
    chk("ovr_flag", 8'(overrun), 8'h01);
    chk("ovr_rdy", 8'(ready_command), 8'h01);
    ack_pulse();
    chk("ovr_ack_rdy", 8'(ready_command), 8'h00);
    chk("ovr_ack_flag", 8'(overrun), 8'h00);
    cycles(20);
    send(8'h06, 1'b1, 1'b0, 160);
    send(8'h07, 1'b1, 1'b1, 160);
    cycles(2);
    chk("same_cycle_cmd", command, 8'h07);
    chk("same_cycle_rdy", 8'(ready_command), 8'h01);
    chk("same_cycle_ov", 8'(overrun), 8'h00);
    cycles(10);
    fe_base = fe_cnt;
    send(8'h55, 1'b1, 1'b0, 88);
    rst = 1'b0;
    rx = 1'b0;
    #1;
    chk("abort_cmd", command, 8'h00);
    chk("abort_rdy", 8'(ready_command), 8'h00);
    chk("abort_ov", 8'(overrun), 8'h00);
    chk("abort_fe", 8'(frame_err), 8'h00);
    cycles(3);
    rst = 1'b1;
    cycles(200);
    chk("low_release_rdy", 8'(ready_command), 8'h00);
    chk("low_release_fe", 8'(fe_cnt - fe_base), 8'h00);
    rx = 1'b1;
    cycles(10);
    send(8'h66, 1'b1, 1'b0, 160);
    cycles(2);
    chk("f66_cmd", command, 8'h66);
    chk("f66_rdy", 8'(ready_command), 8'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
